pcie_os_inserter: RTL and testbench

Parametrised multi-lane symbol multiplexer for the PCIe physical-layer transmit path, sitting between the link-layer byte stream and the per-lane encoders. Each enabled cycle it registers either upstream data bytes or a selected K-code symbol replicated across all lanes. It autonomously inserts SKP ordered sets (COM followed by SKP_LEN SKP symbols) every SKP_INTERVAL data-state cycles, or on request. It back-pressures upstream during insertion through a valid/ready handshake.

---
 rtl/pcie_os_inserter.sv | 196 +++++++++++++++++++
 tb/tb_pcie_os_inserter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_os_inserter.sv
`default_nettype none
// ============================================================================
// Module      : pcie_os_inserter
// Description : Multi-lane transmit symbol multiplexer. Each enabled cycle
//               registers either upstream data bytes or a K-code symbol
//               replicated on every lane. A SKP ordered set (COM followed by
//               SKP_LEN SKP symbols) is inserted autonomously every
//               SKP_INTERVAL data-state cycles, or on i_skp_force. Upstream
//               is stalled through a valid/ready handshake while a set is
//               being sent.
// Ports       :
//   clk           in   clock, all logic on posedge
//   i_reset_L     in   synchronous active-low reset (priority over i_enb)
//   i_enb         in   global enable; low freezes all state and outputs
//   i_sel         in   [3:0] source select (0 data, 1..9 K-codes, 10..15 bad)
//   i_data_in     in   [8*LANES-1:0] upstream data bytes
//   i_valid_in    in   upstream beat valid
//   o_ready_out   out  beat accepted this cycle (combinational)
//   i_skp_force   in   request an immediate SKP ordered set
//   o_data_out    out  [8*LANES-1:0] registered output symbols
//   o_k_out       out  [LANES-1:0] registered per-lane K flag
//   o_skp_active  out  output carries a SKP ordered-set symbol
//   o_sel_err     out  one-cycle pulse on an illegal select value
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_os_inserter #(
    parameter int LANES        = 4,
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_LEN      = 3
) (
    input  wire logic                 clk,
    input  wire logic                 i_reset_L,
    input  wire logic                 i_enb,
    input  wire logic [3:0]           i_sel,
    input  wire logic [8*LANES-1:0]   i_data_in,
    input  wire logic                 i_valid_in,
    output logic                      o_ready_out,
    input  wire logic                 i_skp_force,
    output logic [8*LANES-1:0]        o_data_out,
    output logic [LANES-1:0]          o_k_out,
    output logic                      o_skp_active,
    output logic                      o_sel_err
);

    localparam int c_IW = $clog2(SKP_INTERVAL);
    localparam int c_BW = $clog2(SKP_LEN + 1);

    localparam logic [c_IW-1:0] c_INT_LAST  = c_IW'(SKP_INTERVAL - 1);
    localparam logic [c_BW-1:0] c_BODY_LAST = c_BW'(SKP_LEN - 1);

    localparam logic [7:0] c_COM = 8'hBC;
    localparam logic [7:0] c_PAD = 8'hF7;
    localparam logic [7:0] c_SKP = 8'h1C;
    localparam logic [7:0] c_STP = 8'hFB;
    localparam logic [7:0] c_SDP = 8'h5C;
    localparam logic [7:0] c_END = 8'hFD;
    localparam logic [7:0] c_EDB = 8'hFE;
    localparam logic [7:0] c_FTS = 8'h3C;
    localparam logic [7:0] c_IDL = 8'h7C;

    typedef enum logic [1:0] {
        ST_DATA     = 2'd0,
        ST_SKP_COM  = 2'd1,
        ST_SKP_BODY = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IW-1:0]      r_int_cnt;
    logic [c_BW-1:0]      r_body_cnt;
    logic [8*LANES-1:0]   r_data_out;
    logic [LANES-1:0]     r_k_out;
    logic                 r_skp_active;
    logic                 r_sel_err;

    state_t               w_state_nxt;
    logic [c_IW-1:0]      w_int_nxt;
    logic [c_BW-1:0]      w_body_nxt;
    logic [8*LANES-1:0]   w_data_nxt;
    logic [LANES-1:0]     w_k_nxt;
    logic                 w_skp_nxt;
    logic                 w_err_nxt;
    logic [7:0]           w_sym;
    logic                 w_sel_illegal;

    // K-code lookup; illegal selects fall back to IDL and flag an error.
    always_comb begin
        w_sym         = c_IDL;
        w_sel_illegal = 1'b0;
        case (i_sel)
            4'd1:    w_sym = c_COM;
            4'd2:    w_sym = c_PAD;
            4'd3:    w_sym = c_SKP;
            4'd4:    w_sym = c_STP;
            4'd5:    w_sym = c_SDP;
            4'd6:    w_sym = c_END;
            4'd7:    w_sym = c_EDB;
            4'd8:    w_sym = c_FTS;
            4'd9:    w_sym = c_IDL;
            4'd0:    w_sym = c_IDL;
            default: w_sel_illegal = 1'b1;
        endcase
    end

    // Data is only accepted from the DATA state with the data source selected.
    assign o_ready_out = i_enb && (r_state == ST_DATA) && (i_sel == 4'd0);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_int_nxt   = r_int_cnt;
        w_body_nxt  = r_body_cnt;
        w_data_nxt  = r_data_out;
        w_k_nxt     = r_k_out;
        w_skp_nxt   = r_skp_active;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_DATA: begin
                w_skp_nxt = 1'b0;
                if (i_sel == 4'd0) begin
                    if (i_valid_in) begin
                        w_data_nxt = i_data_in;
                        w_k_nxt    = '0;
                    end else begin
                        w_data_nxt = {LANES{c_IDL}};
                        w_k_nxt    = '1;
                    end
                end else begin
                    w_data_nxt = {LANES{w_sym}};
                    w_k_nxt    = '1;
                    w_err_nxt  = w_sel_illegal;
                end
                // A force that coincides with expiry still yields one set.
                if ((r_int_cnt == c_INT_LAST) || i_skp_force) begin
                    w_int_nxt   = '0;
                    w_state_nxt = ST_SKP_COM;
                end else begin
                    w_int_nxt = r_int_cnt + c_IW'(1);
                end
            end

            ST_SKP_COM: begin
                w_data_nxt  = {LANES{c_COM}};
                w_k_nxt     = '1;
                w_skp_nxt   = 1'b1;
                w_body_nxt  = '0;
                w_state_nxt = ST_SKP_BODY;
            end

            ST_SKP_BODY: begin
                w_data_nxt = {LANES{c_SKP}};
                w_k_nxt    = '1;
                w_skp_nxt  = 1'b1;
                if (r_body_cnt == c_BODY_LAST) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_body_nxt = r_body_cnt + c_BW'(1);
                end
            end

            default: begin
                w_state_nxt = ST_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_L) begin
            r_state      <= ST_DATA;
            r_int_cnt    <= '0;
            r_body_cnt   <= '0;
            r_data_out   <= '0;
            r_k_out      <= '0;
            r_skp_active <= 1'b0;
            r_sel_err    <= 1'b0;
        end else if (i_enb) begin
            r_state      <= w_state_nxt;
            r_int_cnt    <= w_int_nxt;
            r_body_cnt   <= w_body_nxt;
            r_data_out   <= w_data_nxt;
            r_k_out      <= w_k_nxt;
            r_skp_active <= w_skp_nxt;
            r_sel_err    <= w_err_nxt;
        end else begin
            // The error flag is a pulse; it must not linger across a stall.
            r_sel_err    <= 1'b0;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_k_out      = r_k_out;
    assign o_skp_active = r_skp_active;
    assign o_sel_err    = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_pcie_os_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_os_inserter
// Description : Self-checking bench for pcie_os_inserter (LANES=2,
//               SKP_INTERVAL=4, SKP_LEN=2). A reference model keeps a queue of
//               pending ordered-set symbols and a count of data-state cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_os_inserter;

    localparam int c_L    = 2;
    localparam int c_INTV = 4;
    localparam int c_SLEN = 2;

    logic              clk = 1'b0;
    logic              rst_L;
    logic              enb;
    logic [3:0]        sel;
    logic [8*c_L-1:0]  data_in;
    logic              valid_in;
    logic              ready_out;
    logic              skp_force;
    logic [8*c_L-1:0]  data_out;
    logic [c_L-1:0]    k_out;
    logic              skp_active;
    logic              sel_err;

    always #5 clk = ~clk;

    pcie_os_inserter #(
        .LANES        (c_L),
        .SKP_INTERVAL (c_INTV),
        .SKP_LEN      (c_SLEN)
    ) u_dut (
        .clk          (clk),
        .i_reset_L    (rst_L),
        .i_enb        (enb),
        .i_sel        (sel),
        .i_data_in    (data_in),
        .i_valid_in   (valid_in),
        .o_ready_out  (ready_out),
        .i_skp_force  (skp_force),
        .o_data_out   (data_out),
        .o_k_out      (k_out),
        .o_skp_active (skp_active),
        .o_sel_err    (sel_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]        ins_q[$];
    int                dcnt;
    bit                known = 1'b0;
    bit                rnd_mode = 1'b0;
    logic [8*c_L-1:0]  exp_data;
    logic [c_L-1:0]    exp_k;
    logic              exp_skp;
    logic              exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sym_of(input logic [3:0] s);
        case (s)
            4'd1:    return 8'hBC;
            4'd2:    return 8'hF7;
            4'd3:    return 8'h1C;
            4'd4:    return 8'hFB;
            4'd5:    return 8'h5C;
            4'd6:    return 8'hFD;
            4'd7:    return 8'hFE;
            4'd8:    return 8'h3C;
            default: return 8'h7C;
        endcase
    endfunction

    function automatic logic [8*c_L-1:0] next_beat(input logic [8*c_L-1:0] cur);
        if (rnd_mode) return (8*c_L)'($urandom);
        return {cur[15:8] + 8'd2, cur[7:0] + 8'd2};
    endfunction

    // One clock: check ready, step the model, clock, check outputs.
    task automatic cycle(input string tag);
        logic       exp_rdy;
        logic       xfer;
        logic [7:0] b;
        #1;
        exp_rdy = enb && (ins_q.size() == 0) && (sel == 4'd0);
        if (known) chk({tag, ":ready"}, {31'd0, ready_out}, {31'd0, exp_rdy});
        xfer = known && rst_L && valid_in && exp_rdy;

        if (!rst_L) begin
            exp_data = '0; exp_k = '0; exp_skp = 1'b0; exp_err = 1'b0;
            ins_q.delete();
            dcnt  = 0;
            known = 1'b1;
        end else if (known) begin
            if (!enb) begin
                exp_err = 1'b0;
            end else if (ins_q.size() > 0) begin
                b        = ins_q.pop_front();
                exp_data = {c_L{b}};
                exp_k    = '1;
                exp_skp  = 1'b1;
                exp_err  = 1'b0;
            end else begin
                if (sel == 4'd0 && valid_in) begin
                    exp_data = data_in;
                    exp_k    = '0;
                end else begin
                    exp_data = {c_L{sym_of(sel)}};
                    exp_k    = '1;
                end
                exp_skp = 1'b0;
                exp_err = (sel >= 4'd10);
                dcnt++;
                if (dcnt == c_INTV || skp_force) begin
                    dcnt = 0;
                    ins_q.push_back(8'hBC);
                    repeat (c_SLEN) ins_q.push_back(8'h1C);
                end
            end
        end

        @(posedge clk);
        #1;
        if (known) begin
            chk({tag, ":data"}, {16'd0, data_out}, {16'd0, exp_data});
            chk({tag, ":k"},    {30'd0, k_out},    {30'd0, exp_k});
            chk({tag, ":skp"},  {31'd0, skp_active}, {31'd0, exp_skp});
            chk({tag, ":err"},  {31'd0, sel_err},  {31'd0, exp_err});
        end
        if (xfer) data_in = next_beat(data_in);
    endtask

    task automatic do_reset();
        rst_L = 1'b0; valid_in = 1'b0; skp_force = 1'b0; sel = 4'd0;
        cycle("reset");
        rst_L = 1'b1;
    endtask

    logic [15:0] t1_tbl [8];
    logic [15:0] held;

    initial begin
        rst_L = 1'b1; enb = 1'b0; sel = 4'd0; data_in = '0;
        valid_in = 1'b0; skp_force = 1'b0;
        t1_tbl = '{16'h0201, 16'h0403, 16'h0605, 16'h0807,
                   16'hBCBC, 16'h1C1C, 16'h1C1C, 16'h0A09};

        // Reset has priority over a low enable.
        enb = 1'b0;
        do_reset();
        chk("reset_data", {16'd0, data_out}, 32'd0);
        chk("reset_k", {30'd0, k_out}, 32'd0);

        // Streaming data with periodic SKP insertion.
        enb = 1'b1; sel = 4'd0; valid_in = 1'b1; data_in = 16'h0201;
        for (int i = 0; i < 8; i++) begin
            cycle("stream");
            chk("stream_const", {16'd0, data_out}, {16'd0, t1_tbl[i]});
        end
        repeat (14) cycle("stream_rep");

        // Every legal K-code select.
        do_reset();
        valid_in = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            sel = 4'(s);
            cycle("ksel");
        end
        sel = 4'd0;
        repeat (4) cycle("ksel_post");

        // Illegal select pulses the error flag once.
        do_reset();
        sel = 4'hC; valid_in = 1'b0;
        cycle("illegal");
        chk("illegal_data", {16'd0, data_out}, 32'h7C7C);
        chk("illegal_err", {31'd0, sel_err}, 32'd1);
        sel = 4'd0;
        cycle("illegal_after");
        chk("illegal_err_clr", {31'd0, sel_err}, 32'd0);

        // Forced SKP at int_cnt=1.
        do_reset();
        valid_in = 1'b1;
        cycle("force_pre");
        skp_force = 1'b1;
        cycle("force");
        skp_force = 1'b0;
        cycle("force_com");
        chk("force_com_const", {16'd0, data_out}, 32'hBCBC);
        repeat (10) cycle("force_post");

        // Enable drop during the first SKP body cycle.
        do_reset();
        valid_in = 1'b1;
        repeat (5) cycle("stall_pre");
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall_hold", {16'd0, data_out}, 32'hBCBC);
        end
        enb = 1'b1;
        repeat (4) cycle("stall_post");

        // Reset while in SKP_COM.
        do_reset();
        valid_in = 1'b1;
        repeat (4) cycle("abort_pre");
        rst_L = 1'b0; valid_in = 1'b0;
        cycle("abort");
        chk("abort_skp", {31'd0, skp_active}, 32'd0);
        rst_L = 1'b1; valid_in = 1'b1;
        held = data_in;
        cycle("abort_post");
        chk("abort_pass", {16'd0, data_out}, {16'd0, held});
        repeat (5) cycle("abort_tail");

        // Randomized traffic against the model.
        rnd_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rst_L     = ($urandom_range(0, 99) != 0);
            enb       = ($urandom_range(0, 9) != 0);
            sel       = ($urandom_range(0, 7) < 5) ? 4'd0 : 4'($urandom_range(1, 15));
            valid_in  = rst_L && ($urandom_range(0, 3) != 0);
            skp_force = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
